// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM port arbiter: FSM states, transaction owner,
// bus widths and the data word returned to a requester whose transaction was aborted.
package sdram_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 16;

    localparam logic [DATA_W-1:0] ERR_DATA = 16'hDEAD;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CART_RD,
        ST_HOST_RD,
        ST_HOST_WR,
        ST_RESP
    } state_t;

    typedef enum logic {
        OWNER_CART,
        OWNER_HOST
    } owner_t;

endpackage

// File: rtl/sdram_arb_prio.sv
// Grant decision: cart has fixed priority, host is forced after MAX_CART_RUN cart grants
// while it waits. Combinational grant, registered run counter; grants only when arb_en.
module sdram_arb_prio
    import sdram_arb_pkg::*;
#(
    parameter int MAX_CART_RUN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic arb_en,
    input  logic cart_rd,
    input  logic host_rd,
    input  logic host_wr,
    output logic gnt_cart,
    output logic gnt_host_wr,
    output logic gnt_host_rd
);

    localparam int CW = $clog2(MAX_CART_RUN + 1);

    logic [CW-1:0] run_cnt;
    logic          host_pend;
    logic          force_host;

    assign host_pend  = host_rd | host_wr;
    assign force_host = host_pend && (run_cnt == CW'(MAX_CART_RUN));

    // A simultaneous host read and write request is always served as the write.
    always_comb begin
        gnt_cart    = 1'b0;
        gnt_host_wr = 1'b0;
        gnt_host_rd = 1'b0;
        if (arb_en) begin
            if (force_host) begin
                gnt_host_wr = host_wr;
                gnt_host_rd = !host_wr;
            end else if (cart_rd) begin
                gnt_cart = 1'b1;
            end else if (host_wr) begin
                gnt_host_wr = 1'b1;
            end else if (host_rd) begin
                gnt_host_rd = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            run_cnt <= '0;
        end else if (!host_pend || gnt_host_wr || gnt_host_rd) begin
            run_cnt <= '0;
        end else if (gnt_cart && run_cnt != CW'(MAX_CART_RUN)) begin
            run_cnt <= run_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM read/write port between cart (priority) and host; ack = mem ack + 1 cycle.
// Requests are level-held until ack; optional watchdog abort under ARB_TIMEOUT_EN.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter logic [ADDR_W-1:0] CART_BASE    = 32'h0000_0000,
    parameter int                MAX_CART_RUN = 8,
    parameter int                TIMEOUT      = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cart_rd,
    input  logic [ADDR_W-1:0] cart_addr,
    output logic [DATA_W-1:0] cart_data,
    output logic              cart_ack,
    input  logic              host_rd,
    input  logic              host_wr,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_ack,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rd_ack,
    input  logic              mem_wr_ack,
    output logic              busy,
    output logic              timeout_err
);

    state_t state;
    owner_t owner;
    logic   arb_en;
    logic   gnt_cart, gnt_host_wr, gnt_host_rd;
    logic   rd_done, wr_done, wd_expire;

    assign arb_en  = (state == ST_IDLE);
    assign busy    = (state != ST_IDLE);
    assign rd_done = (state == ST_CART_RD || state == ST_HOST_RD) && mem_rd_ack;
    assign wr_done = (state == ST_HOST_WR) && mem_wr_ack;

    sdram_arb_prio #(
        .MAX_CART_RUN(MAX_CART_RUN)
    ) u_prio (
        .clk        (clk),
        .rst        (rst),
        .arb_en     (arb_en),
        .cart_rd    (cart_rd),
        .host_rd    (host_rd),
        .host_wr    (host_wr),
        .gnt_cart   (gnt_cart),
        .gnt_host_wr(gnt_host_wr),
        .gnt_host_rd(gnt_host_rd)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_cnt;

    // A matching ack in the expiry cycle still completes normally.
    assign wd_expire = (state == ST_CART_RD || state == ST_HOST_RD || state == ST_HOST_WR)
                       && (wd_cnt == WD_W'(TIMEOUT - 1)) && !rd_done && !wr_done;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= wd_expire;
            if (state == ST_IDLE || state == ST_RESP) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end
        end
    end
`else
    assign wd_expire   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            owner      <= OWNER_CART;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cart_data  <= '0;
            cart_ack   <= 1'b0;
            host_rdata <= '0;
            host_ack   <= 1'b0;
        end else begin
            cart_ack <= 1'b0;
            host_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (gnt_cart) begin
                        state    <= ST_CART_RD;
                        owner    <= OWNER_CART;
                        mem_rd   <= 1'b1;
                        mem_addr <= cart_addr + CART_BASE;
                    end else if (gnt_host_wr) begin
                        state     <= ST_HOST_WR;
                        owner     <= OWNER_HOST;
                        mem_wr    <= 1'b1;
                        mem_addr  <= host_addr;
                        mem_wdata <= host_wdata;
                    end else if (gnt_host_rd) begin
                        state    <= ST_HOST_RD;
                        owner    <= OWNER_HOST;
                        mem_rd   <= 1'b1;
                        mem_addr <= host_addr;
                    end
                end
                ST_CART_RD, ST_HOST_RD, ST_HOST_WR: begin
                    // Aborts also pass through RESP so the still-high request is not re-granted.
                    if (rd_done || wr_done || wd_expire) begin
                        mem_rd <= 1'b0;
                        mem_wr <= 1'b0;
                        state  <= ST_RESP;
                        if (owner == OWNER_CART) begin
                            cart_ack  <= 1'b1;
                            cart_data <= wd_expire ? ERR_DATA : mem_rdata;
                        end else begin
                            host_ack <= 1'b1;
                            if (!wr_done) begin
                                host_rdata <= wd_expire ? ERR_DATA : mem_rdata;
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter with a delay-programmable controller responder.
module tb_sdram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cart_rd;
    logic [31:0] cart_addr;
    logic [15:0] cart_data;
    logic        cart_ack;
    logic        host_rd, host_wr;
    logic [31:0] host_addr;
    logic [15:0] host_wdata, host_rdata;
    logic        host_ack;
    logic        mem_rd, mem_wr;
    logic [31:0] mem_addr;
    logic [15:0] mem_wdata, mem_rdata;
    logic        mem_rd_ack, mem_wr_ack;
    logic        busy, timeout_err;

    int total = 0;
    int bad   = 0;

    int          ack_at    = 0;
    bit          wrong_ack = 0;
    logic [15:0] rd_val    = 16'h0;
    int          scnt      = 0;

    int rd_seen = 0, cart_acks = 0, host_acks = 0, te_seen = 0;

    always #5 clk = ~clk;

    sdram_port_arbiter #(
        .CART_BASE   (32'h0100_0000),
        .MAX_CART_RUN(8),
        .TIMEOUT     (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cart_rd    (cart_rd),
        .cart_addr  (cart_addr),
        .cart_data  (cart_data),
        .cart_ack   (cart_ack),
        .host_rd    (host_rd),
        .host_wr    (host_wr),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_rdata (host_rdata),
        .host_ack   (host_ack),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_rd_ack (mem_rd_ack),
        .mem_wr_ack (mem_wr_ack),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the falling edge n cycles later.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
        #1;
    endtask

    task automatic wait_ack(input bit is_host, input int limit, output int cyc);
        cyc = 0;
        do begin
            step(1);
            cyc++;
        end while (!(is_host ? host_ack : cart_ack) && cyc < limit);
        check(is_host ? "host_ack_wait" : "cart_ack_wait", is_host ? host_ack : cart_ack, 1);
    endtask

    // Controller model: ack arrives in the ack_at-th cycle of a strobe (0 = never).
    initial begin
        mem_rd_ack = 1'b0;
        mem_wr_ack = 1'b0;
        mem_rdata  = 16'h0;
        forever begin
            @(negedge clk);
            mem_rd_ack = 1'b0;
            mem_wr_ack = 1'b0;
            if (mem_rd || mem_wr) scnt++;
            else scnt = 0;
            if (wrong_ack && scnt == 1) begin
                if (mem_wr) mem_rd_ack = 1'b1;
                else mem_wr_ack = 1'b1;
            end
            if (ack_at != 0 && scnt == ack_at) begin
                mem_rdata = rd_val;
                if (mem_rd) mem_rd_ack = 1'b1;
                else mem_wr_ack = 1'b1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (mem_rd) rd_seen++;
            if (cart_ack) cart_acks++;
            if (host_ack) host_acks++;
            if (timeout_err) te_seen++;
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int cyc, n, last, c0, h0, rd0, te0;
        logic [31:0] seq;

        rst = 1'b0; cart_rd = 1'b0; cart_addr = '0;
        host_rd = 1'b0; host_wr = 1'b0; host_addr = '0; host_wdata = '0;
        step(2);
        check("rst_mem_rd", mem_rd, 0);
        check("rst_mem_wr", mem_wr, 0);
        check("rst_busy", busy, 0);
        check("rst_acks", {cart_ack, host_ack, timeout_err}, 0);
        check("rst_mem_addr", mem_addr, 0);
        rst = 1'b1;
        step(1);

        // Single cart read, 5-cycle controller delay, base offset applied.
        ack_at = 6; rd_val = 16'hBEEF; cart_addr = 32'h100; cart_rd = 1'b1;
        step(1);
        check("t1_mem_rd", mem_rd, 1);
        check("t1_mem_addr", mem_addr, 32'h0100_0100);
        check("t1_busy", busy, 1);
        step(5);
        check("t1_no_early_ack", cart_ack, 0);
        check("t1_rd_held", mem_rd, 1);
        step(1);
        check("t1_cart_ack", cart_ack, 1);
        check("t1_cart_data", cart_data, 16'hBEEF);
        check("t1_rd_dropped", mem_rd, 0);
        cart_rd = 1'b0;
        step(1);
        check("t1_ack_pulse", cart_ack, 0);
        check("t1_idle", busy, 0);
        check("t1_data_hold", cart_data, 16'hBEEF);

        // Host write; a read ack during the write must be ignored.
        rd0 = rd_seen;
        ack_at = 3; wrong_ack = 1'b1;
        host_addr = 32'h20; host_wdata = 16'h1234; host_wr = 1'b1;
        step(1);
        check("t2_mem_wr", mem_wr, 1);
        check("t2_mem_addr", mem_addr, 32'h20);
        check("t2_mem_wdata", mem_wdata, 16'h1234);
        step(1);
        check("t2_wrong_ack_ignored", mem_wr, 1);
        check("t2_no_early_ack", host_ack, 0);
        step(2);
        check("t2_host_ack", host_ack, 1);
        check("t2_wr_dropped", mem_wr, 0);
        check("t2_no_cart_ack", cart_ack, 0);
        host_wr = 1'b0; wrong_ack = 1'b0;
        step(1);
        check("t2_no_read", rd_seen - rd0, 0);
        check("t2_idle", busy, 0);

        // Host read at minimum controller latency.
        ack_at = 1; rd_val = 16'hC0DE; host_addr = 32'h44; host_rd = 1'b1;
        wait_ack(1, 20, cyc);
        check("t3_latency", cyc, 2);
        check("t3_host_rdata", host_rdata, 16'hC0DE);
        check("t3_mem_addr", mem_addr, 32'h44);
        host_rd = 1'b0;
        step(1);

        // Read and write together: only the write is issued.
        h0 = host_acks; rd0 = rd_seen;
        ack_at = 2; host_addr = 32'h40; host_wdata = 16'h5A5A; host_rd = 1'b1; host_wr = 1'b1;
        step(1);
        check("t4_mem_wr", mem_wr, 1);
        check("t4_mem_rd", mem_rd, 0);
        check("t4_mem_wdata", mem_wdata, 16'h5A5A);
        wait_ack(1, 20, cyc);
        check("t4_rdata_hold", host_rdata, 16'hC0DE);
        host_rd = 1'b0; host_wr = 1'b0;
        step(3);
        check("t4_one_ack", host_acks - h0, 1);
        check("t4_no_read", rd_seen - rd0, 0);
        check("t4_idle", busy, 0);

        // Continuous contention: 8 cart grants then 1 host, grant every 3 cycles.
        ack_at = 1; rd_val = 16'h1111; cart_addr = 32'h200; host_addr = 32'h300;
        cart_rd = 1'b1; host_rd = 1'b1;
        seq = '0; n = 0; last = 0;
        for (int c = 1; c <= 200 && n < 18; c++) begin
            step(1);
            if (cart_ack || host_ack) begin
                seq[n] = host_ack;
                n++;
                last = c;
            end
        end
        cart_rd = 1'b0; host_rd = 1'b0;
        check("t5_pattern", seq, 32'h0002_0100);
        check("t5_count", n, 18);
        check("t5_last_cycle", last, 53);
        step(2);

        // Reset in the middle of a cart read drops it silently.
        c0 = cart_acks;
        ack_at = 0; cart_addr = 32'h300; cart_rd = 1'b1;
        step(3);
        check("t6_inflight", {busy, mem_rd}, 2'b11);
        rst = 1'b0;
        step(1);
        check("t6_rst_mem_rd", mem_rd, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_data", cart_data, 0);
        rst = 1'b1; cart_rd = 1'b0;
        step(3);
        check("t6_no_ack", cart_acks - c0, 0);
        ack_at = 2; rd_val = 16'h7777; cart_addr = 32'hFF00_0010; cart_rd = 1'b1;
        step(1);
        check("t6_addr_wrap", mem_addr, 32'h0000_0010);
        wait_ack(0, 20, cyc);
        check("t6_latency", cyc, 2);
        check("t6_cart_data", cart_data, 16'h7777);
        cart_rd = 1'b0;
        step(1);

        // Controller never acks.
        te0 = te_seen; c0 = cart_acks;
        ack_at = 0; cart_addr = 32'h0; cart_rd = 1'b1;
`ifdef ARB_TIMEOUT_EN
        step(16);
        check("t7_before_timeout", {timeout_err, mem_rd}, 2'b01);
        step(1);
        check("t7_timeout_err", timeout_err, 1);
        check("t7_cart_ack", cart_ack, 1);
        check("t7_err_data", cart_data, 16'hDEAD);
        check("t7_rd_dropped", mem_rd, 0);
        cart_rd = 1'b0;
        step(1);
        check("t7_err_pulse", timeout_err, 0);
`else
        step(40);
        check("t7_still_busy", busy, 1);
        check("t7_still_rd", mem_rd, 1);
        check("t7_no_timeout", te_seen - te0, 0);
        check("t7_no_ack", cart_acks - c0, 0);
        rst = 1'b0; cart_rd = 1'b0;
        step(1);
        rst = 1'b1;
        check("t7_rst_idle", busy, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
